// File: rtl/manhattan_pipe.sv
// Two-stage pipelined Manhattan distance unit: compares |a-b| against |c-b|
// and reports the absolute difference on one selectable axis.
module manhattan_pipe #(
    parameter int DIM     = 3,
    parameter int COORD_W = 8,
    localparam int AXIS_W = (DIM > 1) ? $clog2(DIM) : 1,
    localparam int DIST_W = COORD_W + $clog2(DIM),
    localparam int VEC_W  = DIM * COORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AXIS_W-1:0] axis,
    input  logic [VEC_W-1:0]  a,
    input  logic [VEC_W-1:0]  b,
    input  logic [VEC_W-1:0]  c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIST_W-1:0] dist_ab,
    output logic [DIST_W-1:0] dist_cb,
    output logic [COORD_W-1:0] single_dist,
    output logic              closer
);

    logic [COORD_W-1:0] diff_ab [DIM];
    logic [COORD_W-1:0] diff_cb [DIM];
    logic [COORD_W-1:0] sd_sel;

    logic [COORD_W-1:0] d1_ab [DIM];
    logic [COORD_W-1:0] d1_cb [DIM];
    logic [COORD_W-1:0] sd1;
    logic               v1;

    logic [DIST_W-1:0]  sum_ab;
    logic [DIST_W-1:0]  sum_cb;

    logic [DIST_W-1:0]  sum_ab_r;
    logic [DIST_W-1:0]  sum_cb_r;
    logic [COORD_W-1:0] sd2;
    logic               closer_r;
    logic               v2;

    logic               load1;
    logic               load2;
    logic               take;

    function automatic logic [COORD_W-1:0] absdiff(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

    // Out-of-range axis matches no lane and leaves sd_sel at zero.
    always_comb begin
        sd_sel = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            diff_ab[i] = absdiff(a[i*COORD_W +: COORD_W], b[i*COORD_W +: COORD_W]);
            diff_cb[i] = absdiff(c[i*COORD_W +: COORD_W], b[i*COORD_W +: COORD_W]);
            if (axis == AXIS_W'(i)) begin
                sd_sel = diff_ab[i];
            end
        end
    end

    always_comb begin
        sum_ab = '0;
        sum_cb = '0;
        for (int unsigned i = 0; i < DIM; i++) begin
            sum_ab = sum_ab + DIST_W'(d1_ab[i]);
            sum_cb = sum_cb + DIST_W'(d1_cb[i]);
        end
    end

    assign load2    = !v2 || out_ready;
    assign load1    = !v1 || load2;
    assign in_ready = load1;
    assign take     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            sd1      <= '0;
            sd2      <= '0;
            sum_ab_r <= '0;
            sum_cb_r <= '0;
            closer_r <= 1'b0;
            for (int unsigned i = 0; i < DIM; i++) begin
                d1_ab[i] <= '0;
                d1_cb[i] <= '0;
            end
        end else begin
            if (flush) begin
                v1 <= 1'b0;
                v2 <= 1'b0;
            end else begin
                if (load1) v1 <= in_valid;
                if (load2) v2 <= v1;
            end
            // Data registers only move on real transfers so idle operands never reach the outputs.
            if (take) begin
                sd1 <= sd_sel;
                for (int unsigned i = 0; i < DIM; i++) begin
                    d1_ab[i] <= diff_ab[i];
                    d1_cb[i] <= diff_cb[i];
                end
            end
            if (!flush && load2 && v1) begin
                sum_ab_r <= sum_ab;
                sum_cb_r <= sum_cb;
                sd2      <= sd1;
                closer_r <= (sum_ab < sum_cb);
            end
        end
    end

    assign out_valid   = v2;
    assign dist_ab     = sum_ab_r;
    assign dist_cb     = sum_cb_r;
    assign single_dist = sd2;
    assign closer      = closer_r;

endmodule

// File: doc/manhattan_pipe.md
MANHATTAN_PIPE -- requirements
Module: manhattan_pipe

Interface
REQ-001 Parameter DIM, default 3, number of coordinate axes (>=2).
REQ-002 Parameter COORD_W, default 8, unsigned coordinate width per axis.
REQ-003 Derived localparams: AXIS_W = max(1, clog2(DIM)); DIST_W = COORD_W + clog2(DIM); VEC_W = DIM*COORD_W.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous pipeline clear.
REQ-007 in_valid  input  1  operand set valid.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 axis  input  AXIS_W  split axis for single-axis distance.
REQ-010 a, b, c  input  VEC_W each  a = current point, b = parent/query, c = current best; axis i at bits [i*COORD_W +: COORD_W].
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 dist_ab  output  DIST_W  sum over axes of |a_i - b_i|.
REQ-014 dist_cb  output  DIST_W  sum over axes of |c_i - b_i|.
REQ-015 single_dist  output  COORD_W  |a_axis - b_axis|.
REQ-016 closer  output  1  1 when dist_ab < dist_cb.

Function
REQ-017 Transfer in on in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-018 Two registered stages: S1 latches per-axis absolute differences for a-b and c-b plus the single_dist select; S2 latches both sums and closer.
REQ-019 Latency: inputs accepted at edge N appear at outputs after edge N+2 when unstalled; throughput one result per cycle.
REQ-020 Absolute difference computed unsigned, (x>=y) ? x-y : y-x, full COORD_W range, no sign-bit wrap.
REQ-021 Sums carry DIST_W bits; maximum DIM*(2^COORD_W-1) never overflows.
REQ-022 axis >= DIM yields single_dist = 0 for that result.
REQ-023 closer = 0 on tie (dist_ab == dist_cb).
REQ-024 Stage valid bits v1, v2; S2 loads when !v2 || out_ready; S1 loads when S1 empty or S1 moving into S2.
REQ-025 in_ready = !v1 || !v2 || out_ready (combinational, no dependence on in_valid).
REQ-026 out_valid = v2; outputs and v2 hold stable while out_valid && !out_ready.
REQ-027 No result lost or duplicated under any out_ready pattern; order preserved.
REQ-028 Pipeline capacity is exactly 2 results; with out_ready low and both stages full, in_ready = 0.
REQ-029 flush = 1 clears v1 and v2 at next edge, discards any input presented that cycle; data registers need not clear.
REQ-030 flush has priority over simultaneous in/out transfers; out transfer in flush cycle still counts as consumed.
REQ-031 Operand values outside a valid cycle do not affect any output.

Reset
REQ-032 rst low asynchronously clears v1, v2 and all data registers: out_valid=0, dist_ab=0, dist_cb=0, single_dist=0, closer=0.
REQ-033 in_ready = 1 while in reset and on first cycle after release.
REQ-034 Reset mid-operation discards all in-flight results; none emerge after release.

Verification
REQ-035 DIM=3,COORD_W=8, out_ready=1; a=(10,200,30), b=(20,50,30), c=(0,0,0), axis=1 -> 2 cycles later dist_ab=160, dist_cb=100, single_dist=150, closer=0.
REQ-036 a=(255,255,255), b=(0,0,0), c=b, axis=3 -> dist_ab=765, dist_cb=0, single_dist=0, closer=0; a=c=(5,5,5), b=(1,2,3) -> dist_ab=dist_cb=9, closer=0.
REQ-037 Back-to-back stream of 8 random operand sets, out_ready=1 -> 8 results on consecutive cycles, matching reference model, in_ready constantly 1.
REQ-038 out_ready=0 for 4 cycles while in_valid=1 -> exactly 2 accepted, in_ready=0 thereafter, output held stable; out_ready=1 -> results drain in order, none lost.
REQ-039 Pipeline full, assert rst low for 1 cycle mid-stream -> out_valid=0 immediately, all outputs 0, no stale result after release; repeat with flush -> out_valid=0 next cycle.
